pipeline_stall_ctrl: RTL
========================

# pipeline_stall_ctrl

Pipeline stall/flush controller: consumes `hazard_detected` from hazard detection, `branch_taken` from EXE and the MEM-stage memory handshake, and drives the hold/clear enables of the PC and pipeline registers. It sits beside `hazard_detection` in the 5-stage core and is the only block allowed to freeze or squash pipeline registers. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles `flush_IF_ID` is held per taken branch; legal range 1..3.
- `CNT_W`, default 16: width of the statistics counters.
- `MEM_TIMEOUT`, default 255: wait cycles before `mem_timeout` sets; legal range 1..2^16-1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `hazard_detected`  in  1  RAW hazard on the instruction in ID.
- `branch_taken`  in  1  branch resolved taken in EXE this cycle.
- `mem_req`  in  1  LDR/STR in MEM is accessing memory.
- `mem_ready`  in  1  memory completes the access this cycle.
- `freeze_IF`  out  1  PC holds.
- `freeze_ID`  out  1  IF/ID register holds.
- `bubble_EXE`  out  1  ID/EXE loads a NOP: WB_EN, MEM_R_EN and MEM_W_EN cleared.
- `flush_IF_ID`  out  1  IF/ID register loads a NOP.
- `stall_all`  out  1  PC and all pipeline registers hold.
- `mem_timeout`  out  1  sticky flag: memory wait reached `MEM_TIMEOUT`.
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles.
- `flush_cnt`  out  CNT_W  saturating count of accepted taken branches.

## Operation
- FSM states are RUN, MEM_WAIT and FLUSH.
- Priority in every state: memory wait first, then branch, then hazard.
- RUN:
  - `mem_req & ~mem_ready`: `stall_all`=1, all other control outputs 0. Load wait counter with 1. Go to MEM_WAIT.
  - Else `branch_taken`: `flush_IF_ID`=1, `bubble_EXE`=1, freezes 0, `flush_cnt`+1. `hazard_detected` is ignored. If `FLUSH_CYCLES`>1, load remaining with `FLUSH_CYCLES`-1 and go to FLUSH.
  - Else `hazard_detected`: `freeze_IF`=`freeze_ID`=`bubble_EXE`=1.
- MEM_WAIT:
  - `mem_ready`=0: `stall_all`=1, wait counter +1.
  - When the wait counter equals `MEM_TIMEOUT`, `mem_timeout` sets and stays set. The FSM keeps waiting; it is not aborted.
  - `mem_ready`=1: `stall_all`=0. Branch and hazard are evaluated as in RUN, except a taken branch with `FLUSH_CYCLES`>1 goes to FLUSH. Otherwise go to RUN.
- FLUSH:
  - `flush_IF_ID`=1; `bubble_EXE`, `freeze_IF` and `freeze_ID` are 0. `branch_taken` and `hazard_detected` are ignored because they belong to squashed instructions.
  - `mem_req & ~mem_ready` wins: `stall_all`=1, `flush_IF_ID`=0, remaining not decremented, stay in FLUSH.
  - Otherwise decrement remaining; at 0, go to RUN.
- `stall_cnt` +1 on every cycle with `stall_all` or `freeze_IF` set. `flush_cnt` +1 once per accepted branch. Both saturate at all-ones and never wrap.

## Timing
- Control outputs are Mealy and combinational from state and inputs: zero latency, since a stall must apply in the same cycle the hazard is flagged.
- State, counters and `mem_timeout` update on the rising `clk` edge after the causing cycle.
- Reset values while `rst_n`=0: all control outputs 0, `mem_timeout`=0, both counters 0, state RUN, wait counter and remaining 0.
- Reset mid-MEM_WAIT or mid-FLUSH aborts to RUN with no residual flush.
- `mem_req` and `mem_ready` both high in RUN: no stall.
- Branch and hazard in the same cycle: flush only; no freeze.

## Structure
- Package `pipeline_ctrl_pkg`: state enum typedef (RUN, MEM_WAIT, FLUSH) and the NOP control-bit constants shared with the ID/EXE register.
- One sub-module: `sat_counter` (parameterised width, increment enable, async active-low clear), instantiated for `stall_cnt` and `flush_cnt`.

## Test plan
- Hazard only: `hazard_detected`=1 for 2 cycles in RUN -> `freeze_IF`/`freeze_ID`/`bubble_EXE`=1 in both cycles, `stall_cnt`=2.
- Branch plus hazard, `FLUSH_CYCLES`=2: both high for 1 cycle -> `flush_IF_ID`+`bubble_EXE` in cycle 0, `flush_IF_ID` only in cycle 1, freezes 0, `flush_cnt`=1, back to RUN in cycle 2.
- Memory wait: `mem_req`=1, `mem_ready` low for 3 cycles then high -> `stall_all`=1 for 3 cycles, 0 in the fourth, `stall_cnt`=3.
- Timeout, `MEM_TIMEOUT`=4: `mem_ready` held low -> `mem_timeout` rises after the 4th wait cycle, stays 1 after `mem_ready` returns, `stall_all` still 1 until then.
- Reset mid-MEM_WAIT: deassert `rst_n` during the wait -> outputs 0 immediately, counters 0; after release with idle inputs, outputs stay 0.
- Saturation, `CNT_W`=4: 20 hazard cycles -> `stall_cnt`=15, no wrap.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state encoding,
// the bundled control-output word and the NOP control bits loaded into ID/EXE.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  typedef struct packed {
    logic freeze_IF;
    logic freeze_ID;
    logic bubble_EXE;
    logic flush_IF_ID;
    logic stall_all;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Values the ID/EXE register takes for WB_EN/MEM_R_EN/MEM_W_EN on a bubble.
  localparam logic NOP_WB_EN    = 1'b0;
  localparam logic NOP_MEM_R_EN = 1'b0;
  localparam logic NOP_MEM_W_EN = 1'b0;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/branch/memory inputs and stall/flush/statistics outputs of the controller.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_IF;
  logic             freeze_ID;
  logic             bubble_EXE;
  logic             flush_IF_ID;
  logic             stall_all;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  hazard_detected, branch_taken, mem_req, mem_ready,
    output freeze_IF, freeze_ID, bubble_EXE, flush_IF_ID, stall_all,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    output hazard_detected, branch_taken, mem_req, mem_ready,
    input  freeze_IF, freeze_ID, bubble_EXE, flush_IF_ID, stall_all,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller: Mealy control outputs from state and inputs, with
// sticky memory-timeout flag and saturating stall/flush statistics.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_stall_ctrl_if.master bus
);
  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);
  localparam logic [1:0]  REM_INIT    = 2'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_wait, w_wait_nxt;
  logic [1:0]  r_rem, w_rem_nxt;
  logic        r_timeout;
  logic        w_mem_stall, w_flush_inc, w_to_hit;
  ctrl_t       w_ctrl;
  logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

  assign w_mem_stall = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    w_ctrl      = CTRL_IDLE;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_rem_nxt   = r_rem;
    w_flush_inc = 1'b0;
    w_to_hit    = 1'b0;
    // Outputs are forced idle while reset is held, even with live inputs.
    if (rst_n) begin
      unique case (r_state)
        RUN, MEM_WAIT: begin
          if ((r_state == RUN) ? w_mem_stall : ~bus.mem_ready) begin
            w_ctrl.stall_all = 1'b1;
            w_state_nxt      = MEM_WAIT;
            if (r_state == RUN)          w_wait_nxt = 16'd1;
            else if (r_wait != 16'hFFFF) w_wait_nxt = r_wait + 16'd1;
            w_to_hit = (w_wait_nxt == TIMEOUT_VAL);
          end else begin
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
            if (bus.branch_taken) begin
              w_ctrl.flush_IF_ID = 1'b1;
              w_ctrl.bubble_EXE  = 1'b1;
              w_flush_inc        = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                w_rem_nxt   = REM_INIT;
                w_state_nxt = FLUSH;
              end
            end else if (bus.hazard_detected) begin
              w_ctrl.freeze_IF  = 1'b1;
              w_ctrl.freeze_ID  = 1'b1;
              w_ctrl.bubble_EXE = 1'b1;
            end
          end
        end
        FLUSH: begin
          if (w_mem_stall) begin
            w_ctrl.stall_all = 1'b1;
          end else begin
            w_ctrl.flush_IF_ID = 1'b1;
            w_rem_nxt          = r_rem - 2'd1;
            if (r_rem <= 2'd1) w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_rem     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_rem     <= w_rem_nxt;
      r_timeout <= r_timeout | w_to_hit;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_ctrl.stall_all | w_ctrl.freeze_IF),
    .o_cnt (w_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_flush_inc),
    .o_cnt (w_flush_cnt)
  );

  assign bus.freeze_IF   = w_ctrl.freeze_IF;
  assign bus.freeze_ID   = w_ctrl.freeze_ID;
  assign bus.bubble_EXE  = w_ctrl.bubble_EXE;
  assign bus.flush_IF_ID = w_ctrl.flush_IF_ID;
  assign bus.stall_all   = w_ctrl.stall_all;
  assign bus.mem_timeout = r_timeout;
  assign bus.stall_cnt   = w_stall_cnt;
  assign bus.flush_cnt   = w_flush_cnt;
endmodule
